// File: rtl/mem_initiator_pkg.sv
// Shared constants and helpers for mem_initiator (package mem_bus_pkg).
// Access-size codes, FSM encodings and size-derived helpers used by the initiator and its lane merger.
package mem_bus_pkg;

  typedef logic [1:0] asize_t;

  localparam asize_t ASIZE_BYTE = 2'd0;
  localparam asize_t ASIZE_HALF = 2'd1;
  localparam asize_t ASIZE_WORD = 2'd2;
  localparam asize_t ASIZE_RSVD = 2'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] SPLIT  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  function automatic logic [2:0] beat_count(input asize_t asize);
    case (asize)
      ASIZE_BYTE: beat_count = 3'd1;
      ASIZE_HALF: beat_count = 3'd2;
      ASIZE_WORD: beat_count = 3'd4;
      default:    beat_count = 3'd0;
    endcase
  endfunction

  function automatic logic is_aligned(input asize_t asize, input logic [1:0] addr_lo);
    case (asize)
      ASIZE_BYTE: is_aligned = 1'b1;
      ASIZE_HALF: is_aligned = ~addr_lo[0];
      ASIZE_WORD: is_aligned = (addr_lo == 2'd0);
      default:    is_aligned = 1'b0;
    endcase
  endfunction

  // Load data comes back right-justified; keep only the bytes the access covers.
  function automatic logic [31:0] size_mask(input asize_t asize);
    case (asize)
      ASIZE_BYTE: size_mask = 32'h0000_00FF;
      ASIZE_HALF: size_mask = 32'h0000_FFFF;
      ASIZE_WORD: size_mask = 32'hFFFF_FFFF;
      default:    size_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Request/response and memory-control bundle for mem_initiator.
// master = the initiator itself, slave = the requester plus memory side.
interface mem_initiator_if import mem_bus_pkg::*; #(
  parameter int addr_width = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  asize_t                req_asize;
  logic [addr_width-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_re;
  logic                  mem_we;
  asize_t                mem_asize;
  logic [addr_width-1:0] mem_addr;
  logic                  mem_alignerr;

  modport master (
    input  req_valid, req_we, req_asize, req_addr, req_wdata, mem_alignerr,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_re, mem_we, mem_asize, mem_addr
  );

  modport slave (
    output req_valid, req_we, req_asize, req_addr, req_wdata, mem_alignerr,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_re, mem_we, mem_asize, mem_addr
  );
endinterface

// File: rtl/mem_initiator_lane_merge.sv
// mem_lane_merge: combinational byte-lane helper for split accesses.
// Inserts a loaded byte into the read accumulator and picks the store byte for a lane.
module mem_lane_merge (
  input  logic [31:0] acc_i,
  input  logic [7:0]  rd_byte_i,
  input  logic [1:0]  rd_lane_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  wr_lane_i,
  output logic [31:0] acc_o,
  output logic [7:0]  wr_byte_o
);

  // Place the captured byte at its lane in the accumulator.
  always_comb begin
    acc_o = acc_i;
    case (rd_lane_i)
      2'd0:    acc_o[7:0]   = rd_byte_i;
      2'd1:    acc_o[15:8]  = rd_byte_i;
      2'd2:    acc_o[23:16] = rd_byte_i;
      2'd3:    acc_o[31:24] = rd_byte_i;
      default: acc_o        = acc_i;
    endcase
  end

  // Select the store byte belonging to the lane of the next beat.
  always_comb begin
    case (wr_lane_i)
      2'd0:    wr_byte_o = wdata_i[7:0];
      2'd1:    wr_byte_o = wdata_i[15:8];
      2'd2:    wr_byte_o = wdata_i[23:16];
      2'd3:    wr_byte_o = wdata_i[31:24];
      default: wr_byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: turns load/store requests into memory cycles, splitting misaligned ones
// into byte beats when MEM_INITIATOR_SPLIT_EN is defined (otherwise they error out).
module mem_initiator import mem_bus_pkg::*; #(
  parameter int addr_width = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_initiator_if.master bus,
  inout  wire [31:0]      mem_data
);

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  asize_t                asize_q, asize_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  asize_t                mem_asize_q, mem_asize_d;
  logic [addr_width-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

`ifdef MEM_INITIATOR_SPLIT_EN
  logic [1:0]  beat_q, beat_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  beat_nxt_s;
  logic [31:0] acc_merged_s;
  logic [7:0]  wr_byte_s;
  logic        last_beat_s;

  assign beat_nxt_s  = beat_q + 2'd1;
  assign last_beat_s = ({1'b0, beat_q} == (beat_count(asize_q) - 3'd1));

  mem_lane_merge u_lane_merge (
    .acc_i     (acc_q),
    .rd_byte_i (mem_data[7:0]),
    .rd_lane_i (beat_q),
    .wdata_i   (wdata_q),
    .wr_lane_i (beat_nxt_s),
    .acc_o     (acc_merged_s),
    .wr_byte_o (wr_byte_s)
  );
`endif

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    asize_d      = asize_q;
    addr_d       = addr_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_asize_d  = ASIZE_BYTE;
    mem_addr_d   = '0;
    mem_wdata_d  = 32'h0000_0000;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_err_d   = 1'b0;
`ifdef MEM_INITIATOR_SPLIT_EN
    beat_d       = beat_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          asize_d = bus.req_asize;
          addr_d  = bus.req_addr;
`ifdef MEM_INITIATOR_SPLIT_EN
          wdata_d = bus.req_wdata;
          beat_d  = 2'd0;
          acc_d   = 32'h0000_0000;
`endif
          if (bus.req_asize == ASIZE_RSVD) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (is_aligned(bus.req_asize, bus.req_addr[1:0])) begin
            state_d     = ACCESS;
            mem_re_d    = ~bus.req_we;
            mem_we_d    = bus.req_we;
            mem_asize_d = bus.req_asize;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = bus.req_wdata;
          end else begin
`ifdef MEM_INITIATOR_SPLIT_EN
            state_d     = SPLIT;
            mem_re_d    = ~bus.req_we;
            mem_we_d    = bus.req_we;
            mem_asize_d = ASIZE_BYTE;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = {24'h00_0000, bus.req_wdata[7:0]};
`else
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        if (bus.mem_alignerr) begin
          resp_err_d = 1'b1;
        end else if (!we_q) begin
          resp_rdata_d = mem_data & size_mask(asize_q);
        end else begin
          resp_rdata_d = 32'h0000_0000;
        end
      end
`ifdef MEM_INITIATOR_SPLIT_EN
      SPLIT: begin
        if (bus.mem_alignerr) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (last_beat_s) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0000_0000 : acc_merged_s;
        end else begin
          // Beat addresses wrap naturally at the address width.
          beat_d      = beat_nxt_s;
          acc_d       = acc_merged_s;
          mem_re_d    = ~we_q;
          mem_we_d    = we_q;
          mem_asize_d = ASIZE_BYTE;
          mem_addr_d  = addr_q + addr_width'(beat_nxt_s);
          mem_wdata_d = {24'h00_0000, wr_byte_s};
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      asize_q      <= ASIZE_BYTE;
      addr_q       <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_asize_q  <= ASIZE_BYTE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      asize_q      <= asize_d;
      addr_q       <= addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_asize_q  <= mem_asize_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef MEM_INITIATOR_SPLIT_EN
  // Split-access bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= 2'd0;
      wdata_q <= 32'h0000_0000;
      acc_q   <= 32'h0000_0000;
    end else begin
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
    end
  end
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_asize  = mem_asize_q;
  assign bus.mem_addr   = mem_addr_q;
  assign mem_data       = mem_we_q ? mem_wdata_q : {32{1'bz}};

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed + random traffic against a byte-array model, with a 16-byte
// aligned_ram (4 words) as memory. Build with MEM_INITIATOR_SPLIT_EN to exercise split beats.
module tb_mem_initiator;
  localparam int AW = 4;
`ifdef MEM_INITIATOR_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic err_force;
  logic ram_load;
  wire [31:0] mem_data;
  logic [31:0] ram [4];
  logic [31:0] ram_init [4];
  logic ram_mis;
  logic [31:0] ram_rd;

  always #5 clk = ~clk;

  mem_initiator_if #(.addr_width(AW)) bus();

  mem_initiator #(.addr_width(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .mem_data (mem_data)
  );

  // aligned_ram: right-justified data bus, flags misaligned accesses, never writes on error.
  always_comb begin
    case (bus.mem_asize)
      2'd0:    ram_mis = 1'b0;
      2'd1:    ram_mis = bus.mem_addr[0];
      2'd2:    ram_mis = (bus.mem_addr[1:0] != 2'd0);
      default: ram_mis = 1'b1;
    endcase
  end
  assign bus.mem_alignerr = (bus.mem_re | bus.mem_we) & (ram_mis | err_force);
  assign ram_rd   = ram[bus.mem_addr[3:2]] >> (8 * int'(bus.mem_addr[1:0]));
  assign mem_data = bus.mem_re ? ram_rd : {32{1'bz}};

  always_ff @(posedge clk) begin
    if (ram_load) begin
      for (int w = 0; w < 4; w++) ram[w] <= ram_init[w];
    end else if (bus.mem_we && !bus.mem_alignerr) begin
      for (int b = 0; b < 4; b++)
        if (b < (1 << bus.mem_asize) && (int'(bus.mem_addr[1:0]) + b) < 4)
          ram[bus.mem_addr[3:2]][8*(int'(bus.mem_addr[1:0]) + b) +: 8] <= mem_data[8*b +: 8];
    end
  end

  typedef struct {
    bit        ready, re, we, rv, err, has_lit;
    bit [1:0]  asize;
    bit [3:0]  addr;
    bit [31:0] wmask, wdata, rdata, lit;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  byte unsigned sh [16];

  function automatic exp_t idle_rec();
    exp_t r = '{default: 0};
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic bit misal(input bit [1:0] s, input bit [3:0] a);
    return (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Single compare process: one expected record per cycle while traffic is scheduled.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_ready",  32'(bus.req_ready),  32'(e.ready));
      chk("mem_re",     32'(bus.mem_re),     32'(e.re));
      chk("mem_we",     32'(bus.mem_we),     32'(e.we));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
      if (e.re || e.we) begin
        chk("mem_asize", 32'(bus.mem_asize), 32'(e.asize));
        chk("mem_addr",  32'(bus.mem_addr),  32'(e.addr));
      end
      if (e.we) chk("mem_data", mem_data & e.wmask, e.wdata & e.wmask);
      if (e.rv) begin
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err",   32'(bus.resp_err), 32'(e.err));
      end
      if (e.has_lit) chk("model_pin", e.rdata, e.lit);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b0;
      exp_q.push_back(idle_rec());
      @(posedge clk); #1;
    end
  endtask

  // One request: model its beats, memory effect and response, then drive it cycle by cycle.
  task automatic issue(input bit we, input bit [1:0] sz, input bit [3:0] addr, input bit [31:0] wd,
                       input int inj, input int rbeat, input bit has_lit, input bit [31:0] lit);
    exp_t recs[$];
    exp_t r;
    int nb, nbeats;
    bit split, err, aborted;
    bit [31:0] rd;
    nb = 1 << sz;
    split = misal(sz, addr);
    err = 1'b0;
    aborted = 1'b0;
    rd = 32'h0;
    recs.push_back(idle_rec());
    if (sz == 2'd3 || (split && !SPLIT_EN)) begin
      err = 1'b1;
    end else begin
      nbeats = split ? nb : 1;
      for (int k = 0; k < nbeats; k++) begin
        r = '{default: 0};
        r.re = !we;
        r.we = we;
        r.asize = split ? 2'd0 : sz;
        r.addr  = split ? addr + 4'(k) : addr;
        if (split) begin
          r.wmask = 32'h0000_00FF;
          r.wdata = {24'h0, wd[8*k +: 8]};
        end else begin
          r.wmask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
          r.wdata = wd;
        end
        recs.push_back(r);
        if (k == inj) begin
          err = 1'b1;
          break;
        end
        if (we) begin
          if (split) sh[addr + 4'(k)] = wd[8*k +: 8];
          else for (int i = 0; i < nb; i++) sh[addr + 4'(i)] = wd[8*i +: 8];
        end
        if (k == rbeat) begin
          aborted = 1'b1;
          break;
        end
      end
    end
    if (!we && !err)
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = sh[addr + 4'(i)];
    if (aborted) begin
      recs.push_back(idle_rec());
    end else begin
      r = '{default: 0};
      r.rv = 1'b1;
      r.err = err;
      r.rdata = rd;
      r.has_lit = has_lit;
      r.lit = lit;
      recs.push_back(r);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_asize = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    for (int j = 0; j < recs.size(); j++) begin
      if (j > 0) begin
        rst = (j - 1 == rbeat);
        err_force = (j - 1 == inj);
        if (recs[j].ready) begin
          bus.req_valid = 1'b0;
        end else begin
          bus.req_valid = 1'($urandom);
          bus.req_we    = 1'($urandom);
          bus.req_asize = 2'($urandom);
          bus.req_addr  = 4'($urandom);
          bus.req_wdata = $urandom;
        end
      end
      exp_q.push_back(recs[j]);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    err_force = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    err_force = 1'b0;
    ram_load = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_asize = 2'd0;
    bus.req_addr = 4'd0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) sh[i] = 8'($urandom);
    for (int w = 0; w < 4; w++) ram_init[w] = {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]};
    @(posedge clk); #1;
    exp_q.push_back(idle_rec());
    ram_load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    issue(1'b1, 2'd2, 4'd0, 32'h1122_3344, -1, -1, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 4'd0, 32'h0, -1, -1, 1'b1, 32'h1122_3344);
    issue(1'b0, 2'd3, 4'd0, 32'h0, -1, -1, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 4'd8, 32'h0, 0, -1, 1'b1, 32'h0);
`ifdef MEM_INITIATOR_SPLIT_EN
    issue(1'b1, 2'd2, 4'd5, 32'hAABB_CCDD, -1, -1, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 4'd5, 32'h0, -1, -1, 1'b1, 32'hAABB_CCDD);
    issue(1'b1, 2'd0, 4'd15, 32'h0000_005A, -1, -1, 1'b1, 32'h0);
    issue(1'b0, 2'd1, 4'd15, 32'h0, -1, -1, 1'b1, 32'h0000_445A);
    issue(1'b1, 2'd2, 4'd9, 32'h0102_0304, -1, 2, 1'b0, 32'h0);
    issue(1'b0, 2'd1, 4'd9, 32'h0, -1, -1, 1'b1, 32'h0000_0304);
    issue(1'b1, 2'd2, 4'd13, 32'hDEAD_BEEF, 2, -1, 1'b1, 32'h0);
    issue(1'b0, 2'd1, 4'd13, 32'h0, -1, -1, 1'b1, 32'h0000_BEEF);
`else
    issue(1'b0, 2'd1, 4'd3, 32'h0, -1, -1, 1'b1, 32'h0);
    issue(1'b1, 2'd2, 4'd4, 32'h0102_0304, -1, 0, 1'b0, 32'h0);
    issue(1'b0, 2'd2, 4'd4, 32'h0, -1, -1, 1'b1, 32'h0102_0304);
`endif

    for (int t = 0; t < 250; t++) begin
      bit rwe;
      bit [1:0] rsz;
      bit [3:0] ra;
      int rinj, rnb;
      rwe = 1'($urandom);
      rsz = 2'($urandom);
      ra  = 4'($urandom);
      rnb = misal(rsz, ra) ? (1 << rsz) : 1;
      rinj = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rnb - 1)) : -1;
      issue(rwe, rsz, ra, $urandom, rinj, -1, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
